// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, FSM state type and address/line helpers for the data cache
package cache_pkg;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int LINE_W   = 256;
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_ALLOC,
    S_FILL
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:INDEX_W+OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic logic [2:0] addr_word(input logic [31:0] a);
    return a[OFFSET_W-1:2];
  endfunction

  function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line, input logic [2:0] w);
    return line[{w, 5'b00000} +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [2:0] w, input logic [31:0] d);
    logic [LINE_W-1:0] l;
    l = line;
    l[{w, 5'b00000} +: 32] = d;
    return l;
  endfunction
endpackage

// File: rtl/dcache_tag_array.sv
// rtl/dcache_tag_array.sv - per-line valid/dirty/tag state with one write port and a combinational read
module dcache_tag_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic               set_dirty_i,
  input  logic               clr_dirty_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o
);
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (fill_i) begin
      tag_d[index_i]   = fill_tag_i;
      valid_d[index_i] = 1'b1;
      dirty_d[index_i] = 1'b0;
    end else if (set_dirty_i) begin
      dirty_d[index_i] = 1'b1;
    end else if (clr_dirty_i) begin
      dirty_d[index_i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags are meaningless while valid=0, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data-cache controller
module dcache_controller
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [31:0]         cpu_addr_i,
  input  logic [31:0]         cpu_wdata_i,
  output logic [31:0]         cpu_rdata_o,
  output logic                cpu_stall_o,
  output logic                sram_cs_o,
  output logic                sram_we_o,
  output logic [INDEX_W+1:0]  sram_addr_o,
  output logic [LINE_W-1:0]   sram_wdata_o,
  input  logic [LINE_W-1:0]   sram_rdata_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [LINE_W-1:0]   mem_wdata_o,
  input  logic [LINE_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i
);
  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [2:0]          cpu_word;
  logic                tag_valid, tag_dirty, hit;
  logic [TAG_W-1:0]    tag_rd;
  logic                tag_fill, tag_set_dirty, tag_clr_dirty;
  logic                unused_addr_lsbs;

  assign cpu_tag          = addr_tag(cpu_addr_i);
  assign cpu_index        = addr_index(cpu_addr_i);
  assign cpu_word         = addr_word(cpu_addr_i);
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];
  assign hit              = tag_valid && (tag_rd == cpu_tag);

  dcache_tag_array u_tags (
    .clk         (clk),
    .rst         (rst),
    .index_i     (cpu_index),
    .fill_i      (tag_fill),
    .fill_tag_i  (cpu_tag),
    .set_dirty_i (tag_set_dirty),
    .clr_dirty_i (tag_clr_dirty),
    .valid_o     (tag_valid),
    .dirty_o     (tag_dirty),
    .tag_o       (tag_rd)
  );

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    rdata_d       = rdata_q;
    cpu_rdata_o   = rdata_q;
    cpu_stall_o   = 1'b0;
    sram_cs_o     = 1'b0;
    sram_we_o     = 1'b0;
    sram_addr_o   = '0;
    sram_wdata_o  = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    tag_fill      = 1'b0;
    tag_set_dirty = 1'b0;
    tag_clr_dirty = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          cpu_stall_o = 1'b1;
          sram_cs_o   = 1'b1;
          sram_addr_o = {cpu_index, 2'b00};
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        line_d = sram_rdata_i;
        if (hit) begin
          if (cpu_we_i) begin
            sram_cs_o     = 1'b1;
            sram_we_o     = 1'b1;
            sram_addr_o   = {cpu_index, 2'b00};
            sram_wdata_o  = put_word(sram_rdata_i, cpu_word, cpu_wdata_i);
            tag_set_dirty = 1'b1;
          end else begin
            rdata_d     = get_word(sram_rdata_i, cpu_word);
            cpu_rdata_o = rdata_d;
          end
          state_d = S_IDLE;
        end else begin
          cpu_stall_o = 1'b1;
          state_d     = tag_dirty ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_rd, cpu_index, {OFFSET_W{1'b0}}};
        mem_wdata_o = line_q;
        if (mem_ack_i) begin
          tag_clr_dirty = 1'b1;
          state_d       = S_ALLOC;
        end
      end
      S_ALLOC: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          line_d  = mem_rdata_i;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // The held request replays from IDLE and hits on the freshly filled line.
        cpu_stall_o  = 1'b1;
        sram_cs_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = {cpu_index, 2'b00};
        sram_wdata_o = line_q;
        tag_fill     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset forces every output low immediately, abandoning any memory transaction.
    if (rst) begin
      cpu_rdata_o  = '0;
      cpu_stall_o  = 1'b0;
      sram_cs_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller with SRAM and memory models
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         sram_cs_o, sram_we_o;
  logic [6:0]   sram_addr_o;
  logic [255:0] sram_wdata_o;
  logic [255:0] sram_rd;
  logic         mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i = 1'b0;

  int n_asserts = 0;
  int n_fail = 0;

  logic [255:0] sram_mem [32];
  logic [255:0] wmem [logic [31:0]];
  int           ack_lat = 3;
  int           ack_cnt = 0;
  int           wb_cnt = 0;
  int           rd_cnt = 0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_line = '0;
  logic [31:0]  last_rd_addr = '0;
  logic         mem_seen = 1'b0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rd),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = a + 32'hC0 + w;
    return l;
  endfunction

  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) sram_mem[sram_addr_o[6:2]] <= sram_wdata_o;
      else           sram_rd <= sram_mem[sram_addr_o[6:2]];
    end
  end

  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (rst) begin
      ack_cnt = 0;
    end else if (mem_req_o) begin
      mem_seen = 1'b1;
      ack_cnt++;
      if (ack_cnt >= ack_lat) begin
        ack_cnt = 0;
        mem_ack_i = 1'b1;
        if (mem_we_o) begin
          wb_cnt++;
          last_wb_addr = mem_addr_o;
          last_wb_line = mem_wdata_o;
          wmem[mem_addr_o] = mem_wdata_o;
        end else begin
          rd_cnt++;
          last_rd_addr = mem_addr_o;
          mem_rdata_i = wmem.exists(mem_addr_o) ? wmem[mem_addr_o] : line_pattern(mem_addr_o);
        end
      end
    end else begin
      ack_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && cpu_stall_o) check("req_held_during_stall", {31'b0, cpu_req_i}, 32'd1);
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int cyc, output logic [31:0] rd);
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    cpu_req_i   = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (cpu_stall_o && cyc < 200);
    if (cpu_stall_o) check("access_timeout", 32'd1, 32'd0);
    rd = cpu_rdata_o;
    cpu_req_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int wb_before, rd_before;
    logic [31:0] rd;
    logic [255:0] l;

    #1;
    check("reset_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("reset_sram_cs", {31'b0, sram_cs_o}, 32'd0);
    check("reset_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("reset_rdata", cpu_rdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: cold load miss, clean line, fetch 0x40
    access(1'b0, 32'h0000_0040, '0, cyc, rd);
    check("t1_no_wb", wb_cnt, 32'd0);
    check("t1_fetch_addr", last_rd_addr, 32'h40);
    check("t1_cycles", cyc, 32'd7);
    check("t1_rdata", rd, 32'h100);

    // 2: load hit
    mem_seen = 1'b0;
    access(1'b0, 32'h0000_0044, '0, cyc, rd);
    check("t2_cycles", cyc, 32'd1);
    check("t2_rdata", rd, 32'h101);
    check("t2_no_mem_req", {31'b0, mem_seen}, 32'd0);

    // 3: store hit
    access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, cyc, rd);
    l = sram_mem[2];
    check("t3_cycles", cyc, 32'd1);
    check("t3_word2", l[95:64], 32'hDEAD_BEEF);
    check("t3_word0", l[31:0], 32'h100);
    check("t3_word3", l[127:96], 32'h103);
    check("t3_rdata_held", cpu_rdata_o, 32'h101);

    // 4: conflicting load evicts the dirty line
    access(1'b0, 32'h0000_0440, '0, cyc, rd);
    check("t4_wb_count", wb_cnt, 32'd1);
    check("t4_wb_addr", last_wb_addr, 32'h40);
    check("t4_wb_word2", last_wb_line[95:64], 32'hDEAD_BEEF);
    check("t4_wb_word1", last_wb_line[63:32], 32'h101);
    check("t4_fetch_addr", last_rd_addr, 32'h440);
    check("t4_cycles", cyc, 32'd10);
    check("t4_rdata", rd, 32'h500);

    // 5: reset during ALLOC abandons the fetch and clears valid bits
    ack_lat = 20;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0040;
    cpu_req_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_mem_req_alloc", {31'b0, mem_req_o}, 32'd1);
    check("t5_mem_we_alloc", {31'b0, mem_we_o}, 32'd0);
    rst = 1'b1;
    #1;
    check("t5_mem_req_rst", {31'b0, mem_req_o}, 32'd0);
    check("t5_stall_rst", {31'b0, cpu_stall_o}, 32'd0);
    cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_lat = 3;
    wb_before = wb_cnt;
    rd_before = rd_cnt;
    access(1'b0, 32'h0000_0040, '0, cyc, rd);
    check("t5_refetch", rd_cnt, rd_before + 1);
    check("t5_no_wb", wb_cnt, wb_before);
    check("t5_fetch_addr", last_rd_addr, 32'h40);
    check("t5_cycles", cyc, 32'd7);
    check("t5_rdata", rd, 32'h100);

    // 6: store miss on a clean line, then evict it to prove it became dirty
    wb_before = wb_cnt;
    access(1'b1, 32'h0000_0880, 32'hCAFE_F00D, cyc, rd);
    l = sram_mem[4];
    check("t6_fetch_addr", last_rd_addr, 32'h880);
    check("t6_no_wb", wb_cnt, wb_before);
    check("t6_cycles", cyc, 32'd7);
    check("t6_word0", l[31:0], 32'hCAFE_F00D);
    check("t6_word1", l[63:32], 32'h941);
    access(1'b0, 32'h0000_0C80, '0, cyc, rd);
    check("t6_dirty_wb", wb_cnt, wb_before + 1);
    check("t6_wb_addr", last_wb_addr, 32'h880);
    check("t6_wb_word0", last_wb_line[31:0], 32'hCAFE_F00D);
    check("t6_evict_rdata", rd, 32'hD40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
